// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: shared digit/time types, FSM states and BCD helpers for stopwatch_core.
package stopwatch_pkg;
  typedef logic [3:0] bcd_t;
  typedef struct packed {
    bcd_t m10, m1, s10, s1, c10, c1;
  } time_t;
  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;
  localparam bcd_t MAX9 = 4'd9;
  localparam bcd_t MAX5 = 4'd5;
  localparam time_t TIME_ZERO = '0;
  function automatic bcd_t bcd_next(bcd_t d, bcd_t max, logic inc);
    return inc ? (d == max ? 4'd0 : d + 4'd1) : d;
  endfunction
endpackage

// File: rtl/stopwatch_core_digit.sv
// bcd_digit: one BCD counter stage; carry_out fires when incremented at MAX.
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = MAX9
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry_out
);
  assign carry_out = inc & (digit == MAX);
  always_ff @(posedge clk or negedge rst)
    if (!rst) digit <= '0;
    else digit <= clr ? '0 : bcd_next(digit, MAX, inc);
endmodule

// File: rtl/stopwatch_core.sv
// stopwatch_core: mm:ss.cc BCD stopwatch with start/pause/clear control.
// Optional lap-hold display register enabled by STOPWATCH_LAP_EN.
module stopwatch_core
  import stopwatch_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        cs_tick,
  input  logic        btn_start,
  input  logic        btn_clear,
  input  logic        btn_lap,
  output logic [23:0] time_bcd,
  output logic        running,
  output logic        lap_hold,
  output logic        overflow
);
  state_t state, nstate;
  logic start_prev, clear_prev, start_e, clear_e, clr_act;
  logic [6:0] c;
  bcd_t d [6];
  time_t live;
  assign start_e = btn_start & ~start_prev;
  assign clear_e = btn_clear & ~clear_prev;
  assign clr_act = clear_e & (state != RUN);
  assign nstate = clr_act ? IDLE : start_e ? (state == RUN ? PAUSE : RUN) : state;
  // Registered state gates counting, so a tick on the RUN->PAUSE edge still counts.
  assign c[0] = (state == RUN) & cs_tick;
  assign live = {d[5], d[4], d[3], d[2], d[1], d[0]};
  for (genvar i = 0; i < 6; i++) begin : g_dig
    bcd_digit #(.MAX((i == 3 || i == 5) ? MAX5 : MAX9)) u_digit (
      .clk, .rst, .clr(clr_act), .inc(c[i]), .digit(d[i]), .carry_out(c[i+1])
    );
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      running <= 1'b0;
      overflow <= 1'b0;
      start_prev <= 1'b0;
      clear_prev <= 1'b0;
    end else begin
      start_prev <= btn_start;
      clear_prev <= btn_clear;
      state <= nstate;
      running <= nstate == RUN;
      overflow <= ~clr_act & (overflow | c[6]);
    end
`ifdef STOPWATCH_LAP_EN
  logic lap_prev, lap_e;
  time_t lap_reg, next_live;
  assign lap_e = btn_lap & ~lap_prev;
  // Lap captures the count as it will be after this edge, including a same-cycle tick.
  assign next_live = {bcd_next(d[5], MAX5, c[5]), bcd_next(d[4], MAX9, c[4]),
                      bcd_next(d[3], MAX5, c[3]), bcd_next(d[2], MAX9, c[2]),
                      bcd_next(d[1], MAX9, c[1]), bcd_next(d[0], MAX9, c[0])};
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      lap_prev <= 1'b0;
      lap_hold <= 1'b0;
      lap_reg <= TIME_ZERO;
    end else begin
      lap_prev <= btn_lap;
      if (clr_act) begin
        lap_hold <= 1'b0;
        lap_reg <= TIME_ZERO;
      end else if (lap_e & lap_hold) lap_hold <= 1'b0;
      else if (lap_e & (state == RUN)) begin
        lap_hold <= 1'b1;
        lap_reg <= next_live;
      end
    end
  assign time_bcd = lap_hold ? lap_reg : live;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign lap_hold = 1'b0;
  assign time_bcd = live;
`endif
endmodule

// File: tb/tb_stopwatch_core.sv
// tb_stopwatch_core: table-driven control vectors plus directed multi-cycle sequences.
module tb_stopwatch_core;
`ifdef STOPWATCH_LAP_EN
  localparam bit LAP = 1'b1;
`else
  localparam bit LAP = 1'b0;
`endif
  logic clk = 0, rst = 0, cs_tick = 0, btn_start = 0, btn_clear = 0, btn_lap = 0;
  logic [23:0] time_bcd;
  logic running, lap_hold, overflow;
  int checks = 0, errors = 0;

  stopwatch_core dut (
    .clk(clk), .rst(rst), .cs_tick(cs_tick), .btn_start(btn_start), .btn_clear(btn_clear),
    .btn_lap(btn_lap), .time_bcd(time_bcd), .running(running), .lap_hold(lap_hold),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic st, cl, lp, tk;
    logic [23:0] t;
    logic run, ovf;
  } vec_t;
  vec_t v [14];

  task automatic chk(input string name, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic step(input logic st, input logic cl, input logic lp, input logic tk);
    btn_start = st; btn_clear = cl; btn_lap = lp; cs_tick = tk;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 1);
  endtask

  initial begin
    v[0]  = '{0, 0, 0, 0, 24'h000000, 0, 0};
    v[1]  = '{0, 0, 0, 1, 24'h000000, 0, 0};
    v[2]  = '{1, 0, 0, 1, 24'h000000, 1, 0};
    v[3]  = '{0, 0, 0, 1, 24'h000001, 1, 0};
    v[4]  = '{0, 0, 0, 1, 24'h000002, 1, 0};
    v[5]  = '{1, 0, 0, 1, 24'h000003, 0, 0};
    v[6]  = '{0, 0, 0, 1, 24'h000003, 0, 0};
    v[7]  = '{0, 1, 0, 0, 24'h000000, 0, 0};
    v[8]  = '{1, 0, 0, 0, 24'h000000, 1, 0};
    v[9]  = '{0, 1, 0, 1, 24'h000001, 1, 0};
    v[10] = '{0, 1, 0, 1, 24'h000002, 1, 0};
    v[11] = '{1, 1, 0, 1, 24'h000003, 0, 0};
    v[12] = '{0, 0, 0, 0, 24'h000003, 0, 0};
    v[13] = '{1, 1, 0, 0, 24'h000000, 0, 0};

    for (int i = 0; i < 6; i++) begin
      btn_start = 1'($urandom); btn_clear = 1'($urandom); btn_lap = 1'($urandom);
      cs_tick = 1'($urandom);
      @(posedge clk);
      #1;
    end
    chk("reset_time", time_bcd, 24'h0);
    chk("reset_running", {23'd0, running}, 24'd0);
    chk("reset_lap_hold", {23'd0, lap_hold}, 24'd0);
    chk("reset_overflow", {23'd0, overflow}, 24'd0);
    btn_start = 0; btn_clear = 0; btn_lap = 0; cs_tick = 0;
    @(posedge clk);
    #1 rst = 1;

    for (int i = 0; i < 14; i++) begin
      step(v[i].st, v[i].cl, v[i].lp, v[i].tk);
      chk($sformatf("vec%0d_time", i), time_bcd, v[i].t);
      chk($sformatf("vec%0d_running", i), {23'd0, running}, {23'd0, v[i].run});
      chk($sformatf("vec%0d_overflow", i), {23'd0, overflow}, {23'd0, v[i].ovf});
    end

    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    ticks(100);
    chk("count_100", time_bcd, 24'h000100);
    chk("count_100_running", {23'd0, running}, 24'd1);
    ticks(1);
    chk("count_101", time_bcd, 24'h000101);

    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("clear_after_pause", time_bcd, 24'h0);
    step(1, 0, 0, 0);
    ticks(42);
    step(1, 0, 0, 0);
    chk("pause_42", time_bcd, 24'h000042);
    chk("pause_running", {23'd0, running}, 24'd0);
    ticks(50);
    chk("paused_ticks_ignored", time_bcd, 24'h000042);

    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    ticks(9);
    chk("count_09", time_bcd, 24'h000009);
    step(1, 0, 0, 1);
    chk("pause_tick_counted", time_bcd, 24'h000010);
    chk("pause_tick_running", {23'd0, running}, 24'd0);

    step(0, 0, 0, 0);
    force dut.g_dig[5].u_digit.digit = 4'd5;
    force dut.g_dig[4].u_digit.digit = 4'd9;
    force dut.g_dig[3].u_digit.digit = 4'd5;
    force dut.g_dig[2].u_digit.digit = 4'd9;
    force dut.g_dig[1].u_digit.digit = 4'd9;
    force dut.g_dig[0].u_digit.digit = 4'd9;
    step(0, 0, 0, 0);
    release dut.g_dig[5].u_digit.digit;
    release dut.g_dig[4].u_digit.digit;
    release dut.g_dig[3].u_digit.digit;
    release dut.g_dig[2].u_digit.digit;
    release dut.g_dig[1].u_digit.digit;
    release dut.g_dig[0].u_digit.digit;
    step(0, 0, 0, 0);
    chk("preload", time_bcd, 24'h595999);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("preload_hold", time_bcd, 24'h595999);
    step(0, 0, 0, 1);
    chk("wrap_time", time_bcd, 24'h000000);
    chk("wrap_overflow", {23'd0, overflow}, 24'd1);
    chk("wrap_running", {23'd0, running}, 24'd1);
    ticks(1);
    chk("overflow_sticky", {23'd0, overflow}, 24'd1);
    chk("after_wrap", time_bcd, 24'h000001);
    step(0, 1, 0, 0);
    chk("clear_in_run_ovf", {23'd0, overflow}, 24'd1);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    chk("clear_ovf", {23'd0, overflow}, 24'd0);
    chk("clear_time", time_bcd, 24'h0);
    chk("clear_running", {23'd0, running}, 24'd0);

    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    ticks(250);
    chk("lap_pre", time_bcd, 24'h000250);
    step(0, 0, 1, 0);
    chk("lap_hold_set", {23'd0, lap_hold}, {23'd0, LAP});
    ticks(30);
    chk("lap_frozen", time_bcd, LAP ? 24'h000250 : 24'h000280);
    step(0, 0, 1, 0);
    chk("lap_release", time_bcd, 24'h000280);
    chk("lap_release_hold", {23'd0, lap_hold}, 24'd0);
    step(0, 0, 0, 0);
    step(0, 0, 1, 1);
    chk("lap_same_tick", time_bcd, 24'h000281);
    ticks(1);
    chk("lap_same_tick_held", time_bcd, LAP ? 24'h000281 : 24'h000282);
    step(1, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("lap_release_in_pause", {23'd0, lap_hold}, 24'd0);
    chk("lap_release_time", time_bcd, 24'h000282);
    step(0, 0, 0, 0);
    step(0, 0, 1, 0);
    chk("lap_ignored_in_pause", {23'd0, lap_hold}, 24'd0);

    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    ticks(5);
    chk("pre_reset", time_bcd, 24'h000005);
    btn_start = 1;
    #2 rst = 0;
    #1;
    chk("async_reset_time", time_bcd, 24'h0);
    chk("async_reset_running", {23'd0, running}, 24'd0);
    @(posedge clk);
    #1 rst = 1;
    step(1, 0, 0, 0);
    chk("held_start_after_reset", {23'd0, running}, 24'd1);
    step(0, 0, 0, 1);
    chk("held_start_count", time_bcd, 24'h000001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/stopwatch_core.md
# stopwatch_core

Consumes the single-cycle 100 Hz centisecond tick produced by the team's clock divider. Implements the stopwatch time base: BCD count mm:ss.cc, start/pause/clear control from debounced buttons, and an optional lap-hold display register. Its packed BCD output feeds the seven-segment scan driver directly.

## Interface
- No parameters; digit limits are fixed constants in the package.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  reset, asynchronous, active-low.
- cs_tick  in  1  one-clk-wide pulse at 100 Hz, synchronous to clk.
- btn_start  in  1  debounced level, synchronous; rising edge = start/pause toggle.
- btn_clear  in  1  debounced level, synchronous; rising edge = clear.
- btn_lap  in  1  debounced level, synchronous; rising edge = lap hold/release (functional only with STOPWATCH_LAP_EN).
- time_bcd  out  24  displayed time {m10,m1,s10,s1,c10,c1}, 4 bits each, c1 in [3:0].
- running  out  1  high while state is RUN.
- lap_hold  out  1  high while the display is frozen on a lap value.
- overflow  out  1  sticky; set on wrap from 59:59.99.

## Operation
- Edge detect: each button is registered once (prev). Edge = level & ~prev. A level held high produces exactly one edge.
- States: IDLE (count zero, stopped), RUN, PAUSE.
  - start edge: IDLE->RUN, RUN->PAUSE, PAUSE->RUN.
  - clear edge: IDLE/PAUSE->IDLE. Zeroes count, lap register and overflow, and drops lap_hold. Ignored in RUN.
  - clear and start edges in the same cycle: clear wins if the state is IDLE/PAUSE. In RUN, clear is ignored and start applies.
- Counting: only when the registered state is RUN and cs_tick=1.
  - c1 0..9, then carry to c10 0..9, s1 0..9, s10 0..5, m1 0..9, m10 0..5.
  - Carries ripple within the same cycle; every digit wraps to 0 when its own carry-in fires at its maximum.
  - 59:59.99 + tick -> 00:00.00, overflow<=1, state stays RUN.
- A tick in the same cycle as a RUN->PAUSE start edge is counted. A tick in the same cycle as a PAUSE->RUN or IDLE->RUN edge is not counted.
- Lap (macro on):
  - lap edge in RUN with lap_hold=0: lap register <= next-cycle count (includes a same-cycle tick); lap_hold<=1.
  - lap edge with lap_hold=1, in any state: lap_hold<=0.
  - lap edge in IDLE/PAUSE with lap_hold=0: ignored.
  - time_bcd = lap_hold ? lap register : live count. Counting continues underneath.
- Reset values: state IDLE; time_bcd 0; running 0; lap_hold 0; overflow 0; edge-detect prev registers 0.
- Reset mid-count: asynchronous and immediate, no partial state retained. A button still held high at reset release produces an edge on the first clk, since prev=0.

## Timing
- All outputs are registered.
- Button edge first sampled at clk edge k: the state change and the running/lap_hold updates are visible after edge k.
- A tick sampled at edge k is visible on time_bcd after edge k (1-cycle latency). Full carry chain within that cycle; no multi-cycle paths.
- No back-pressure; cs_tick is never dropped while in RUN.

## Configuration
- STOPWATCH_LAP_EN defined: lap register (24 bits), lap_hold logic and the display mux are compiled in.
- Not defined: btn_lap is unused, lap_hold is tied 0, and time_bcd is always the live count. The port list is unchanged.

## Structure
- Package stopwatch_pkg holds:
  - bcd_t (4-bit digit) and time_t (packed struct of six bcd_t).
  - state enum {IDLE, RUN, PAUSE}.
  - digit maximum constants (9, 5) and TIME_ZERO.
- Sub-module bcd_digit: inputs clk, rst, clr, inc, a MAX constant; outputs digit and carry_out (= inc & digit==MAX). Instantiated six times in a carry chain.

## Test plan
- Reset: hold rst=0 with random buttons -> time_bcd=0, running=0, lap_hold=0, overflow=0.
- Start, then 100 cs_tick pulses -> time_bcd=00:01.00, running=1; one more tick -> 00:01.01.
- Preload by running to 59:59.99, then one tick -> 00:00.00, overflow=1, running=1. Pause, then clear -> overflow=0, IDLE.
- Pause at 00:00.42, apply 50 ticks -> still 00:00.42. Clear edge while in RUN -> ignored, counting continues.
- Start edge and tick in the same cycle from RUN at 00:00.09 -> 00:00.10, running=0 next cycle.
- Lap (macro on): at 00:02.50, lap edge, then 30 ticks -> time_bcd holds 00:02.50, lap_hold=1. Lap edge again -> time_bcd=00:02.80.
